// File: rtl/unified_issue_queue_v2.sv
// Unified issue queue: sits between rename/dispatch and the functional units.
// Accepts one renamed instruction per cycle (valid/ready), captures operands from
// N_CDB result buses, and issues per FU the oldest entry whose operands are ready.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              squash all entries at the next edge
//   disp_*             dispatch request, payload and per-source ready/value
//   cdb_valid/tag/data result broadcast buses (bus i at slice i)
//   fu_ready           per-FU "can accept next cycle"
//   issue_*            registered per-FU issue pulse and payload
//   occupancy, full, empty  registered occupancy status
module unified_issue_queue_v2 #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_FU    = 3,
  parameter int unsigned FU_W    = 2,
  parameter int unsigned N_CDB   = 3,
  parameter int unsigned ROB_W   = 6,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [FU_W-1:0]          disp_fu,
  input  logic [TAG_W-1:0]         disp_rd,
  input  logic [ROB_W-1:0]         disp_rob,
  input  logic [TAG_W-1:0]         disp_rs1,
  input  logic [TAG_W-1:0]         disp_rs2,
  input  logic                     disp_rs1_rdy,
  input  logic                     disp_rs2_rdy,
  input  logic [DATA_W-1:0]        disp_rs1_val,
  input  logic [DATA_W-1:0]        disp_rs2_val,
  input  logic [DATA_W-1:0]        disp_imm,
  input  logic [N_CDB-1:0]         cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]  cdb_data,
  input  logic [N_FU-1:0]          fu_ready,
  output logic [N_FU-1:0]          issue_valid,
  output logic [N_FU*TAG_W-1:0]    issue_rd,
  output logic [N_FU*ROB_W-1:0]    issue_rob,
  output logic [N_FU*DATA_W-1:0]   issue_rs1_val,
  output logic [N_FU*DATA_W-1:0]   issue_rs2_val,
  output logic [N_FU*DATA_W-1:0]   issue_imm,
  output logic [CNT_W-1:0]         occupancy,
  output logic                     full,
  output logic                     empty
);

  logic [RS_SIZE-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  // older_q[j][i] set means entry j is older than entry i
  logic [RS_SIZE-1:0] older_q [RS_SIZE];
  logic [RS_SIZE-1:0] older_d [RS_SIZE];
  logic [RS_SIZE-1:0] older_col [RS_SIZE];
  logic [FU_W-1:0]    fu_q [RS_SIZE],   fu_d [RS_SIZE];
  logic [TAG_W-1:0]   rd_q [RS_SIZE],   rd_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE],  rob_d [RS_SIZE];
  logic [TAG_W-1:0]   tag1_q [RS_SIZE], tag1_d [RS_SIZE];
  logic [TAG_W-1:0]   tag2_q [RS_SIZE], tag2_d [RS_SIZE];
  logic [DATA_W-1:0]  val1_q [RS_SIZE], val1_d [RS_SIZE];
  logic [DATA_W-1:0]  val2_q [RS_SIZE], val2_d [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE],  imm_d [RS_SIZE];
  logic [CNT_W-1:0]   occ_q, occ_d, n_iss;

  logic [RS_SIZE-1:0] elig [N_FU];
  logic [RS_SIZE-1:0] gnt [N_FU];
  logic [RS_SIZE-1:0] issued, free_oh;
  logic               accept;
  logic               src1_rdy, src2_rdy;
  logic [DATA_W-1:0]  src1_val, src2_val;

  logic [N_FU-1:0]         issue_valid_q;
  logic [N_FU*TAG_W-1:0]   issue_rd_q;
  logic [N_FU*ROB_W-1:0]   issue_rob_q;
  logic [N_FU*DATA_W-1:0]  issue_rs1_q, issue_rs2_q, issue_imm_q;

  // Status is derived purely from registered occupancy, so a slot freed by issue
  // only becomes visible to dispatch one cycle later.
  assign disp_ready    = (occ_q != CNT_W'(RS_SIZE));
  assign full          = ~disp_ready;
  assign empty         = (occ_q == '0);
  assign occupancy     = occ_q;
  assign accept        = disp_valid & disp_ready;
  assign issue_valid   = issue_valid_q;
  assign issue_rd      = issue_rd_q;
  assign issue_rob     = issue_rob_q;
  assign issue_rs1_val = issue_rs1_q;
  assign issue_rs2_val = issue_rs2_q;
  assign issue_imm     = issue_imm_q;

  // Age-ordered select: an eligible entry wins if no other eligible entry is older.
  always_comb begin
    issued = '0;
    n_iss  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) older_col[i][j] = older_q[j][i];
    end
    for (int f = 0; f < N_FU; f++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        elig[f][i] = valid_q[i] & rdy1_q[i] & rdy2_q[i] & fu_ready[f] &
                     (fu_q[i] == FU_W'(f));
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        gnt[f][i] = elig[f][i] & ~(|(elig[f] & older_col[i]));
      end
      issued = issued | gnt[f];
      if (|gnt[f]) n_iss = n_iss + CNT_W'(1);
    end
  end

  // Dispatch-side source resolution: tag 0, then explicit ready, then CDB bypass
  // (lowest bus index wins).
  always_comb begin
    src1_rdy = disp_rs1_rdy;
    src1_val = disp_rs1_val;
    src2_rdy = disp_rs2_rdy;
    src2_val = disp_rs2_val;
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (!disp_rs1_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_rs1) begin
        src1_rdy = 1'b1;
        src1_val = cdb_data[c*DATA_W +: DATA_W];
      end
      if (!disp_rs2_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_rs2) begin
        src2_rdy = 1'b1;
        src2_val = cdb_data[c*DATA_W +: DATA_W];
      end
    end
    if (disp_rs1 == '0) begin
      src1_rdy = 1'b1;
      src1_val = '0;
    end
    if (disp_rs2 == '0) begin
      src2_rdy = 1'b1;
      src2_val = '0;
    end
  end

  always_comb begin
    free_oh = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q & ~issued;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    older_d = older_q;
    fu_d    = fu_q;
    rd_d    = rd_q;
    rob_d   = rob_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    imm_d   = imm_q;
    occ_d   = occ_q + CNT_W'(accept) - n_iss;

    // Wakeup: descending loop so the lowest matching bus is applied last.
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (valid_q[i] && cdb_valid[c]) begin
          if (!rdy1_q[i] && cdb_tag[c*TAG_W +: TAG_W] == tag1_q[i]) begin
            rdy1_d[i] = 1'b1;
            val1_d[i] = cdb_data[c*DATA_W +: DATA_W];
          end
          if (!rdy2_q[i] && cdb_tag[c*TAG_W +: TAG_W] == tag2_q[i]) begin
            rdy2_d[i] = 1'b1;
            val2_d[i] = cdb_data[c*DATA_W +: DATA_W];
          end
        end
      end
    end

    if (accept) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (free_oh[i]) begin
          valid_d[i] = 1'b1;
          fu_d[i]    = disp_fu;
          rd_d[i]    = disp_rd;
          rob_d[i]   = disp_rob;
          tag1_d[i]  = disp_rs1;
          tag2_d[i]  = disp_rs2;
          rdy1_d[i]  = src1_rdy;
          rdy2_d[i]  = src2_rdy;
          val1_d[i]  = src1_val;
          val2_d[i]  = src2_val;
          imm_d[i]   = disp_imm;
          // New entry is younger than everything currently valid.
          older_d[i] = '0;
          for (int k = 0; k < RS_SIZE; k++) older_d[k][i] = valid_q[k];
        end
      end
    end

    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      occ_q         <= '0;
      issue_valid_q <= '0;
      issue_rd_q    <= '0;
      issue_rob_q   <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_imm_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      occ_q   <= occ_d;
      older_q <= older_d;
      if (flush) begin
        issue_valid_q <= '0;
      end else begin
        for (int f = 0; f < N_FU; f++) begin
          issue_valid_q[f] <= |gnt[f];
          for (int i = 0; i < RS_SIZE; i++) begin
            if (gnt[f][i]) begin
              issue_rd_q[f*TAG_W +: TAG_W]    <= rd_q[i];
              issue_rob_q[f*ROB_W +: ROB_W]   <= rob_q[i];
              issue_rs1_q[f*DATA_W +: DATA_W] <= val1_q[i];
              issue_rs2_q[f*DATA_W +: DATA_W] <= val2_q[i];
              issue_imm_q[f*DATA_W +: DATA_W] <= imm_q[i];
            end
          end
        end
      end
    end
  end

  // Entry payload needs no reset: it is only observed while valid.
  always_ff @(posedge clk) begin
    fu_q   <= fu_d;
    rd_q   <= rd_d;
    rob_q  <= rob_d;
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    val1_q <= val1_d;
    val2_q <= val2_d;
    imm_q  <= imm_d;
  end

  // An out-of-range FU index would sit in the queue forever.
  disp_fu_range_a : assert property (@(posedge clk) disable iff (rst)
    !(disp_valid && disp_ready && (32'(disp_fu) >= N_FU)));

endmodule
